// File: rtl/sipo_deframer_if.sv
// Parallel output bus of the SIPO deframer: completed word, its parity status and the
// valid/ready handshake. The deframer drives it through the master modport.
interface sipo_deframer_if #(
   parameter int unsigned WIDTH = 4
);
   logic [WIDTH-1:0] dout;
   logic             dout_valid;
   logic             dout_ready;
   logic             parity_err;

   modport master (
      output dout,
      output dout_valid,
      output parity_err,
      input  dout_ready
   );

   modport slave (
      input  dout,
      input  dout_valid,
      input  parity_err,
      output dout_ready
   );
endinterface

// File: rtl/sipo_deframer.sv
// Serial-in/parallel-out deframer. Shifts in one bit per enabled clock (MSB first),
// hands each completed word to a one-word holding register with a valid/ready handshake,
// and raises a sticky overflow when a completed word finds the holding register full.
// Optional feature macro: PARITY_CHECK_EN -- frames carry a trailing even-parity bit and
// parity_err reports the check result alongside each delivered word.
module sipo_deframer #(
   parameter int unsigned WIDTH = 4
) (
   input  logic                         clk,
   input  logic                         clr_n,
   input  logic                         din,
   input  logic                         din_en,
   input  logic                         flush,
   input  logic                         ovf_clr,
   output logic                         overflow,
   output logic [$clog2(WIDTH+1)-1:0]   bit_cnt,
   sipo_deframer_if.master              dbus
);

   localparam int unsigned CW = $clog2(WIDTH + 1);

`ifdef PARITY_CHECK_EN
   localparam int unsigned FL = WIDTH + 1;
`else
   localparam int unsigned FL = WIDTH;
`endif

   // The shift register keeps only the bits that still feed the next word: without parity
   // the final data bit goes straight from din into the word, so WIDTH-1 bits suffice.
   localparam int unsigned SW = FL - 1;

   typedef enum logic {StEmpty, StFull} hold_state_e;

   hold_state_e        state_q, state_d;
   logic [SW-1:0]      shreg_q, shreg_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [WIDTH-1:0]   dout_q, dout_d;
   logic               perr_q, perr_d;
   logic               ovf_q, ovf_d;

   logic               sample;
   logic               last;
   logic               complete;
   logic               consume;
   logic               drop;
   logic [WIDTH-1:0]   new_word;
   logic               new_perr;

   // Framing: shift register and bit counter next state, plus the word being completed.
   always_comb begin
      sample   = din_en & ~flush;
      last     = (cnt_q == CW'(FL - 1));
      complete = sample & last;
      shreg_d  = shreg_q;
      cnt_d    = cnt_q;
      if (flush) begin
         shreg_d = '0;
         cnt_d   = '0;
      end else if (din_en) begin
`ifdef PARITY_CHECK_EN
         // The parity bit is not data; keep the assembled word in place.
         if (!last) begin
            shreg_d = SW'({shreg_q, din});
         end
`else
         shreg_d = SW'({shreg_q, din});
`endif
         cnt_d = last ? '0 : cnt_q + CW'(1);
      end
`ifdef PARITY_CHECK_EN
      new_word = shreg_q;
      new_perr = (^shreg_q) ^ din;
`else
      new_word = {shreg_q, din};
      new_perr = 1'b0;
`endif
   end

   // Holding register: load on completion when empty or being consumed, otherwise drop.
   always_comb begin
      state_d = state_q;
      dout_d  = dout_q;
      perr_d  = perr_q;
      drop    = 1'b0;
      consume = (state_q == StFull) & dbus.dout_ready;
      unique case (state_q)
         StEmpty: begin
            if (complete) begin
               state_d = StFull;
               dout_d  = new_word;
               perr_d  = new_perr;
            end
         end
         StFull: begin
            if (complete) begin
               if (consume) begin
                  dout_d = new_word;
                  perr_d = new_perr;
               end else begin
                  drop = 1'b1;
               end
            end else if (consume) begin
               state_d = StEmpty;
            end
         end
         default: state_d = StEmpty;
      endcase
      // A drop on the same edge as a clear leaves the flag set.
      if (drop) begin
         ovf_d = 1'b1;
      end else if (ovf_clr) begin
         ovf_d = 1'b0;
      end else begin
         ovf_d = ovf_q;
      end
   end

   // State registers with asynchronous clear.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state_q <= StEmpty;
         shreg_q <= '0;
         cnt_q   <= '0;
         dout_q  <= '0;
         perr_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         cnt_q   <= cnt_d;
         dout_q  <= dout_d;
         perr_q  <= perr_d;
         ovf_q   <= ovf_d;
      end
   end

   assign dbus.dout       = dout_q;
   assign dbus.dout_valid = (state_q == StFull);
   assign dbus.parity_err = perr_q;
   assign overflow        = ovf_q;
   assign bit_cnt         = cnt_q;

endmodule
